// File: rtl/vga_text_pkg.sv
// vga_text_pkg: shared text-mode geometry and arbiter state/grant encodings.
package vga_text_pkg;
    localparam int TEXT_COLS   = 80;
    localparam int TEXT_ROWS   = 60;
    localparam int TEXT_DEPTH  = TEXT_COLS * TEXT_ROWS;
    localparam int TEXT_ADDR_W = 13;
    typedef enum logic {WB_EMPTY, WB_FULL} wb_state_t;
    typedef enum logic [1:0] {GNT_NONE, GNT_DISP, GNT_WB, GNT_CPU_RD} grant_t;
endpackage

// File: rtl/text_wr_buffer.sv
// text_wr_buffer: one-entry posted CPU write buffer; out-of-range writes are dropped.
module text_wr_buffer
    import vga_text_pkg::*;
#(
    parameter int DEPTH      = TEXT_DEPTH,
    parameter int ADDR_WIDTH = TEXT_ADDR_W
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  disp_req,
    input  logic                  wr_accept,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [7:0]            wr_data,
    output logic                  full,
    output logic                  wr_ready,
    output logic [ADDR_WIDTH-1:0] buf_addr,
    output logic [7:0]            buf_data
);
    wb_state_t state, state_nxt;
    logic      load, drain;
    always_comb begin
        full      = state == WB_FULL;
        drain     = full && !disp_req;
        wr_ready  = !full || !disp_req;
        load      = wr_accept && (32'(wr_addr) < 32'(DEPTH));
        state_nxt = load ? WB_FULL : (drain ? WB_EMPTY : state);
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= WB_EMPTY;
            buf_addr <= '0;
            buf_data <= '0;
        end else begin
            state <= state_nxt;
            if (load) begin
                buf_addr <= wr_addr;
                buf_data <= wr_data;
            end
        end
    end
endmodule

// File: rtl/text_mem_arbiter.sv
// text_mem_arbiter: shares the text RAM port between display fetches (top priority),
// posted CPU writes and stalled CPU reads.
module text_mem_arbiter
    import vga_text_pkg::*;
#(
    parameter int DEPTH        = TEXT_DEPTH,
    parameter int ADDR_WIDTH   = TEXT_ADDR_W,
    parameter int STARVE_LIMIT = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  disp_req,
    input  logic [ADDR_WIDTH-1:0] disp_addr,
    output logic                  disp_valid,
    output logic [7:0]            disp_data,
    input  logic                  cpu_req,
    input  logic                  cpu_write,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [7:0]            cpu_wdata,
    output logic                  cpu_ready,
    output logic                  cpu_rvalid,
    output logic [7:0]            cpu_rdata,
    output logic                  cpu_starved,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic                  ram_we,
    output logic [7:0]            ram_wdata,
    input  logic [7:0]            ram_rdata
);
    localparam int CW = $clog2(STARVE_LIMIT + 1);
    logic                  wb_full, wb_ready, wr_accept, rd_accept, rd_oor, blocked;
    logic                  disp_p1, rd_p1, rd_oor_p1;
    logic [ADDR_WIDTH-1:0] wb_addr, last_addr;
    logic [7:0]            wb_data;
    logic [CW-1:0]         starve_cnt;
    grant_t                grant;
    text_wr_buffer #(.DEPTH(DEPTH), .ADDR_WIDTH(ADDR_WIDTH)) u_wr_buffer (
        .clk       (clk),
        .reset     (reset),
        .disp_req  (disp_req),
        .wr_accept (wr_accept),
        .wr_addr   (cpu_addr),
        .wr_data   (cpu_wdata),
        .full      (wb_full),
        .wr_ready  (wb_ready),
        .buf_addr  (wb_addr),
        .buf_data  (wb_data)
    );
    // Reads wait for an empty buffer so they always observe earlier posted writes.
    always_comb begin
        cpu_ready = cpu_write ? wb_ready : (!disp_req && !wb_full);
        wr_accept = cpu_req && cpu_write && cpu_ready;
        rd_accept = cpu_req && !cpu_write && cpu_ready;
        blocked   = cpu_req && !cpu_ready;
        rd_oor    = 32'(cpu_addr) >= 32'(DEPTH);
        grant     = disp_req ? GNT_DISP : wb_full ? GNT_WB : rd_accept ? GNT_CPU_RD : GNT_NONE;
        ram_we    = grant == GNT_WB;
        ram_wdata = wb_data;
        ram_addr  = grant == GNT_DISP   ? disp_addr :
                    grant == GNT_WB     ? wb_addr   :
                    grant == GNT_CPU_RD ? cpu_addr  : last_addr;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            last_addr   <= '0;
            disp_p1     <= 1'b0;
            rd_p1       <= 1'b0;
            rd_oor_p1   <= 1'b0;
            disp_valid  <= 1'b0;
            cpu_rvalid  <= 1'b0;
            disp_data   <= '0;
            cpu_rdata   <= '0;
            starve_cnt  <= '0;
            cpu_starved <= 1'b0;
        end else begin
            last_addr  <= ram_addr;
            disp_p1    <= disp_req;
            rd_p1      <= rd_accept;
            rd_oor_p1  <= rd_oor;
            disp_valid <= disp_p1;
            cpu_rvalid <= rd_p1;
            if (disp_p1) disp_data <= ram_rdata;
            if (rd_p1) cpu_rdata <= rd_oor_p1 ? 8'h00 : ram_rdata;
            starve_cnt <= !blocked ? '0 :
                          (starve_cnt == CW'(STARVE_LIMIT)) ? starve_cnt : starve_cnt + 1'b1;
            if (blocked && starve_cnt == CW'(STARVE_LIMIT - 1)) cpu_starved <= 1'b1;
        end
    end
endmodule

// File: tb/tb_text_mem_arbiter.sv
// tb_text_mem_arbiter: scoreboard bench for text_mem_arbiter with a behavioural text RAM.
module tb_text_mem_arbiter;
    logic        clk = 0;
    logic        reset, disp_req, cpu_req, cpu_write;
    logic [12:0] disp_addr, cpu_addr, ram_addr;
    logic [7:0]  cpu_wdata, disp_data, cpu_rdata, ram_wdata, ram_rdata;
    logic        disp_valid, cpu_ready, cpu_rvalid, cpu_starved, ram_we;
    typedef struct {
        logic [7:0] data;
        int         due;
    } exp_t;
    exp_t        disp_q[$], cpu_q[$];
    logic [7:0]  mem [8192];
    logic [7:0]  ref_mem [8192];
    int          cyc = 0, checks = 0, failures = 0, we_cnt = 0, disp_pulses = 0;
    int          w, wc, p;
    text_mem_arbiter dut (
        .clk        (clk),
        .reset      (reset),
        .disp_req   (disp_req),
        .disp_addr  (disp_addr),
        .disp_valid (disp_valid),
        .disp_data  (disp_data),
        .cpu_req    (cpu_req),
        .cpu_write  (cpu_write),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_ready  (cpu_ready),
        .cpu_rvalid (cpu_rvalid),
        .cpu_rdata  (cpu_rdata),
        .cpu_starved(cpu_starved),
        .ram_addr   (ram_addr),
        .ram_we     (ram_we),
        .ram_wdata  (ram_wdata),
        .ram_rdata  (ram_rdata)
    );
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) begin
        if (cyc == 0) begin
            for (int i = 0; i < 8192; i++) mem[i] <= 8'(i * 7 + 3);
        end else begin
            if (ram_we) mem[ram_addr] <= ram_wdata;
            ram_rdata <= mem[ram_addr];
        end
    end
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask
    always @(negedge clk) begin
        exp_t e;
        if (ram_we) we_cnt++;
        if (disp_valid) begin
            disp_pulses++;
            if (disp_q.size() == 0) check("disp_unexpected", 1, 0);
            else begin
                e = disp_q.pop_front();
                check("disp_data", disp_data, e.data);
                check("disp_latency", cyc, e.due);
            end
        end
        if (cpu_rvalid) begin
            if (cpu_q.size() == 0) check("rvalid_unexpected", 1, 0);
            else begin
                e = cpu_q.pop_front();
                check("cpu_rdata", cpu_rdata, e.data);
                check("rd_latency", cyc, e.due);
            end
        end
    end
    task automatic nxt();
        @(posedge clk);
        #1;
    endtask
    task automatic idle(input int n);
        repeat (n) nxt();
    endtask
    task automatic do_reset();
        reset = 1; cpu_req = 0; disp_req = 0;
        nxt();
        disp_q.delete();
        cpu_q.delete();
        nxt();
        reset = 0;
    endtask
    task automatic push_disp(input logic [12:0] a);
        exp_t e;
        e.data = ref_mem[a];
        e.due  = cyc + 2;
        disp_q.push_back(e);
    endtask
    task automatic cpu_wr(input logic [12:0] a, input logic [7:0] d, output int waited);
        cpu_req = 1; cpu_write = 1; cpu_addr = a; cpu_wdata = d; waited = 0;
        @(negedge clk);
        while (!cpu_ready && waited < 50) begin
            nxt();
            @(negedge clk);
            waited++;
        end
        if (!cpu_ready) check("wr_timeout", 1, 0);
        else if (a < 13'd4800) ref_mem[a] = d;
        nxt();
        cpu_req = 0;
    endtask
    task automatic cpu_rd(input logic [12:0] a, output int waited);
        exp_t e;
        cpu_req = 1; cpu_write = 0; cpu_addr = a; waited = 0;
        @(negedge clk);
        while (!cpu_ready && waited < 50) begin
            nxt();
            @(negedge clk);
            waited++;
        end
        if (!cpu_ready) check("rd_timeout", 1, 0);
        else begin
            e.data = (a < 13'd4800) ? ref_mem[a] : 8'h00;
            e.due  = cyc + 2;
            cpu_q.push_back(e);
        end
        nxt();
        cpu_req = 0;
    endtask
    initial begin
        #200000;
        check("global_timeout", 1, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end
    initial begin
        reset = 1; cpu_req = 0; cpu_write = 0; cpu_addr = 0; cpu_wdata = 0;
        disp_req = 0; disp_addr = 0;
        for (int i = 0; i < 8192; i++) ref_mem[i] = 8'(i * 7 + 3);
        idle(3);
        reset = 0;
        @(negedge clk);
        check("rst_disp_valid", disp_valid, 0);
        check("rst_cpu_rvalid", cpu_rvalid, 0);
        check("rst_ram_we", ram_we, 0);
        check("rst_starved", cpu_starved, 0);
        check("rst_ram_addr", ram_addr, 0);
        check("rst_disp_data", disp_data, 0);
        check("rst_cpu_rdata", cpu_rdata, 0);
        check("rst_cpu_ready", cpu_ready, 1);
        nxt();
        cpu_wr(13'd5, 8'h41, w);
        check("wr5_wait", w, 0);
        @(negedge clk);
        check("wr5_we", ram_we, 1);
        check("wr5_addr", ram_addr, 5);
        check("wr5_wdata", ram_wdata, 8'h41);
        nxt();
        cpu_rd(13'd5, w);
        check("rd5_wait", w, 0);
        idle(3);
        cpu_wr(13'd10, 8'h11, w);
        disp_req = 1; disp_addr = 13'd200;
        cpu_req = 1; cpu_write = 1; cpu_addr = 13'd11; cpu_wdata = 8'h22;
        for (int k = 0; k < 10; k++) begin
            push_disp(13'd200);
            @(negedge clk);
            check("hold_we", ram_we, 0);
            check("hold_ready", cpu_ready, 0);
            nxt();
        end
        disp_req = 0;
        @(negedge clk);
        check("drain_we", ram_we, 1);
        check("drain_addr", ram_addr, 10);
        check("drain_ready", cpu_ready, 1);
        ref_mem[11] = 8'h22;
        nxt();
        cpu_req = 0;
        @(negedge clk);
        check("drain2_we", ram_we, 1);
        check("drain2_addr", ram_addr, 11);
        check("drain2_wdata", ram_wdata, 8'h22);
        nxt();
        cpu_rd(13'd10, w);
        cpu_rd(13'd11, w);
        check("rd_b2b_wait", w, 0);
        idle(3);
        cpu_wr(13'd100, 8'h7E, w);
        cpu_rd(13'd100, w);
        check("raw_stall", w, 1);
        idle(3);
        wc = we_cnt;
        cpu_wr(13'd4800, 8'h55, w);
        check("oor_wr_wait", w, 0);
        cpu_rd(13'd4801, w);
        check("oor_rd_wait", w, 0);
        idle(4);
        check("oor_no_we", we_cnt - wc, 0);
        cpu_req = 1; cpu_write = 0; cpu_addr = 13'd300;
        for (int k = 1; k <= 20; k++) begin
            disp_req = 1; disp_addr = 13'd200;
            push_disp(13'd200);
            @(negedge clk);
            if (k == 1) check("starve_blocked", cpu_ready, 0);
            if (k == 15) check("starve_early", cpu_starved, 0);
            if (k == 17) check("starve_set", cpu_starved, 1);
            nxt();
        end
        disp_req = 0;
        begin
            exp_t e;
            @(negedge clk);
            check("starve_accept", cpu_ready, 1);
            e.data = ref_mem[300];
            e.due  = cyc + 2;
            cpu_q.push_back(e);
        end
        nxt();
        cpu_req = 0;
        idle(4);
        @(negedge clk);
        check("starve_sticky", cpu_starved, 1);
        do_reset();
        @(negedge clk);
        check("starve_cleared", cpu_starved, 0);
        nxt();
        p = disp_pulses;
        for (int a = 0; a < 8; a++) begin
            disp_req = 1; disp_addr = 13'(a);
            push_disp(13'(a));
            nxt();
        end
        disp_req = 0;
        idle(5);
        check("disp_8_pulses", disp_pulses - p, 8);
        p = disp_pulses;
        for (int a = 0; a < 4; a++) begin
            disp_req = 1; disp_addr = 13'(a);
            push_disp(13'(a));
            nxt();
        end
        disp_req = 0;
        do_reset();
        idle(6);
        check("disp_after_reset", disp_pulses - p, 3);
        check("disp_q_left", disp_q.size(), 0);
        check("cpu_q_left", cpu_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
